// File: rtl/serial_comparator_multi_digit_fsm.sv
// -----------------------------------------------------------------------------
// serial_comparator_multi_digit_fsm
//
// Framed serial magnitude comparator. Operands A and B arrive one DIGIT_W-bit
// digit per beat, either most-significant digit first (MSB_FIRST=1) or
// least-significant digit first (MSB_FIRST=0). A one-hot relation FSM
// (LESS/EQ/GREATER) tracks the relation of the digits seen so far. The running
// relation, including the digit on the bus, is visible every cycle. The final
// relation of a word is latched one cycle after its last digit, together with a
// one-cycle res_valid pulse.
//
// Optional feature (compile-time macro SERIAL_CMP_SIGNED_EN):
//   When defined, operands are two's complement. The sign digit is the first
//   digit of a word when MSB_FIRST=1, or the in_last digit when MSB_FIRST=0.
//   On that digit the top bit of a and b is inverted before the compare, which
//   turns the two's-complement order into plain unsigned (offset-binary) order.
//   When undefined, every digit compares unsigned and no sign logic exists.
//
// Parameters:
//   DIGIT_W    bits per beat on a/b (>= 1)
//   MSB_FIRST  1: most significant digit first, 0: least significant first
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   in_valid     a/b/in_last carry a digit this cycle (no backpressure)
//   in_last      final digit of the current word (only meaningful with in_valid)
//   a, b         digits of operands A and B
//   a_less_b     running relation including the current beat (next state)
//   a_eq_b       running relation including the current beat
//   a_greater_b  running relation including the current beat
//   res_valid    one-cycle pulse the cycle after an in_valid & in_last beat
//   res_lt       latched final A <  B, held until the next res_valid
//   res_eq       latched final A == B
//   res_gt       latched final A >  B
// -----------------------------------------------------------------------------
module serial_comparator_multi_digit_fsm #(
  parameter int DIGIT_W   = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_last,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b,
  output logic               res_valid,
  output logic               res_lt,
  output logic               res_eq,
  output logic               res_gt
);

  // One-hot relation encoding; the bit order matches {lt, eq, gt}.
  typedef enum logic [2:0] {
    ST_LESS    = 3'b100,
    ST_EQ      = 3'b010,
    ST_GREATER = 3'b001
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  state_t             base_state_s;
  logic               first_r;
  logic               res_valid_r;
  logic [2:0]         res_r;
  logic [DIGIT_W-1:0] a_cmp_s;
  logic [DIGIT_W-1:0] b_cmp_s;
  logic               digit_lt_s;
  logic               digit_gt_s;
  logic               word_end_s;

`ifdef SERIAL_CMP_SIGNED_EN
  logic               sign_digit_s;

  // The sign digit is the first digit of an MSB-first word, or the closing
  // digit of an LSB-first word.
  assign sign_digit_s = MSB_FIRST ? first_r : in_last;
`endif

  assign word_end_s = in_valid & in_last;

  // Operand conditioning: on the sign digit the top bits are flipped so that
  // an unsigned compare yields the two's-complement ordering.
  always_comb begin
    a_cmp_s = a;
    b_cmp_s = b;
`ifdef SERIAL_CMP_SIGNED_EN
    if (sign_digit_s) begin
      a_cmp_s[DIGIT_W-1] = ~a[DIGIT_W-1];
      b_cmp_s[DIGIT_W-1] = ~b[DIGIT_W-1];
    end else begin
      a_cmp_s = a;
      b_cmp_s = b;
    end
`endif
  end

  assign digit_lt_s = (a_cmp_s < b_cmp_s);
  assign digit_gt_s = (a_cmp_s > b_cmp_s);

  // Starting state for this beat: the first digit of a word always compares
  // against EQ, so a new word never needs a separate clear cycle.
  always_comb begin
    base_state_s = state_r;
    if (first_r) begin
      base_state_s = ST_EQ;
    end else begin
      base_state_s = state_r;
    end
  end

  // Next-state logic of the relation FSM.
  always_comb begin
    next_state_s = state_r;
    if (in_valid) begin
      if (MSB_FIRST) begin
        // The first differing digit from the top decides the word; once
        // decided the relation is sticky until the word ends.
        case (base_state_s)
          ST_EQ: begin
            if (digit_lt_s) begin
              next_state_s = ST_LESS;
            end else if (digit_gt_s) begin
              next_state_s = ST_GREATER;
            end else begin
              next_state_s = ST_EQ;
            end
          end
          ST_LESS:    next_state_s = ST_LESS;
          ST_GREATER: next_state_s = ST_GREATER;
          default:    next_state_s = ST_EQ;
        endcase
      end else begin
        // Least significant first: each later differing digit outranks all
        // earlier ones, so any inequality overrides; equality keeps the state.
        if (digit_lt_s) begin
          next_state_s = ST_LESS;
        end else if (digit_gt_s) begin
          next_state_s = ST_GREATER;
        end else begin
          next_state_s = base_state_s;
        end
      end
    end else begin
      next_state_s = state_r;
    end
  end

  // Relation state and word-start flag; gaps (in_valid=0) hold everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_EQ;
      first_r <= 1'b1;
    end else if (in_valid) begin
      if (in_last) begin
        state_r <= ST_EQ;
      end else begin
        state_r <= next_state_s;
      end
      first_r <= in_last;
    end else begin
      state_r <= state_r;
      first_r <= first_r;
    end
  end

  // Final result latch and one-cycle completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_r       <= 3'b010;
    end else begin
      res_valid_r <= word_end_s;
      if (word_end_s) begin
        res_r <= next_state_s;
      end else begin
        res_r <= res_r;
      end
    end
  end

  assign {a_less_b, a_eq_b, a_greater_b} = next_state_s;
  assign res_valid                       = res_valid_r;
  assign {res_lt, res_eq, res_gt}        = res_r;

endmodule
